// File: rtl/timer_counter.sv
// ---------------------------------------------------------------------------
// timer_counter
//
// Memory-mapped down-counting timer with a maskable interrupt. The bus bridge
// has already matched the address window, so only the word offset Addr[3:2]
// is decoded here:
//   0 CTRL   : [3] IM, [2:1] Mode, [0] En (bits [7:4] = prescale P when
//              TC_PRESCALE_EN is defined, otherwise read as 0)
//   1 PRESET : R/W reload value
//   2 COUNT  : read-only current count
//   3        : reserved, reads 0, writes ignored
//
// Ports:
//   clk    - system clock, all state changes on the rising edge
//   reset  - synchronous, active-high reset
//   Addr   - word address [31:2]
//   WE     - write strobe (full-word stores only)
//   Din    - write data
//   Dout   - read data, combinational on Addr[3:2]
//   IRQ    - level interrupt request = irq_flag & IM
//
// Optional feature macro: TC_PRESCALE_EN (adds the CTRL[7:4] prescaler).
// ---------------------------------------------------------------------------
module timer_counter #(
    parameter logic [31:0] PRESET_RST = 32'h0,
    parameter int          COUNT_W    = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] MODE_AUTO  = 2'd1;

    state_t               state_q;
    logic                 en_q;
    logic [1:0]           mode_q;
    logic                 im_q;
    logic                 irq_flag_q;
    logic [COUNT_W-1:0]   preset_q;
    logic [COUNT_W-1:0]   count_q;

    logic                 wr_ctrl;
    logic                 wr_preset;
    logic                 en_eff;
    logic                 cnt_step;
    logic [3:0]           presc_rd;

    // The upper address bits are already decoded by the bridge.
    logic                 unused_addr;
    assign unused_addr = ^Addr[31:4];

    assign wr_ctrl   = WE && (Addr[3:2] == OFF_CTRL);
    assign wr_preset = WE && (Addr[3:2] == OFF_PRESET);

    // A CTRL write landing this cycle already decides whether counting goes
    // on, so a disable freezes COUNT at the value it shows right now.
    assign en_eff = wr_ctrl ? Din[0] : en_q;

`ifdef TC_PRESCALE_EN
    logic [3:0] presc_q;
    logic [3:0] ps_cnt_q;

    assign presc_rd = presc_q;
    // COUNT moves only when the prescaler has seen P+1 CNT cycles.
    assign cnt_step = (ps_cnt_q == presc_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q  <= 4'd0;
            ps_cnt_q <= 4'd0;
        end else begin
            if (wr_ctrl) begin
                presc_q <= Din[7:4];
            end
            if ((state_q == S_LOAD) || !en_eff) begin
                ps_cnt_q <= 4'd0;
            end else if (state_q == S_CNT) begin
                ps_cnt_q <= cnt_step ? 4'd0 : ps_cnt_q + 4'd1;
            end
        end
    end
`else
    assign presc_rd = 4'd0;
    assign cnt_step = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            en_q       <= 1'b0;
            mode_q     <= 2'd0;
            im_q       <= 1'b0;
            irq_flag_q <= 1'b0;
            preset_q   <= PRESET_RST[COUNT_W-1:0];
            count_q    <= '0;
        end else begin
            if (wr_ctrl) begin
                en_q   <= Din[0];
                mode_q <= Din[2:1];
                im_q   <= Din[3];
            end
            if (wr_preset) begin
                preset_q <= Din[COUNT_W-1:0];
            end

            // Setting in INT beats the CTRL-write clear; auto-reload mode
            // drops the flag one edge after it rose.
            if (state_q == S_INT) begin
                irq_flag_q <= 1'b1;
            end else if (wr_ctrl || (mode_q == MODE_AUTO)) begin
                irq_flag_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (en_q) begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    count_q <= preset_q;
                    state_q <= S_CNT;
                end
                S_CNT: begin
                    if (!en_eff) begin
                        state_q <= S_IDLE;
                    end else if (cnt_step) begin
                        if (count_q > COUNT_W'(1)) begin
                            count_q <= count_q - COUNT_W'(1);
                        end else begin
                            count_q <= '0;
                            state_q <= S_INT;
                        end
                    end
                end
                S_INT: begin
                    state_q <= S_IDLE;
                    // One-shot modes disarm themselves unless software is
                    // rewriting CTRL on this very edge.
                    if (!wr_ctrl && (mode_q != MODE_AUTO)) begin
                        en_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        Dout = 32'h0;
        case (Addr[3:2])
            OFF_CTRL:   Dout = {24'h0, presc_rd, im_q, mode_q, en_q};
            OFF_PRESET: Dout = 32'(preset_q);
            OFF_COUNT:  Dout = 32'(count_q);
            default:    Dout = 32'h0;
        endcase
    end

    assign IRQ = irq_flag_q & im_q;

endmodule

// File: tb/tb_timer_counter.sv
module tb_timer_counter;

    localparam logic [31:0] PRESET_RST = 32'h0000_00A5;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];

    timer_counter #(
        .PRESET_RST (PRESET_RST),
        .COUNT_W    (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [1:0] off, input logic [31:0] data);
        Addr = {28'h0, off};
        Din  = data;
        WE   = 1'b1;
        tick();
        WE   = 1'b0;
        $display("[%0t] WR off=%0d data=0x%08h", $time, off, data);
    endtask

    task automatic rd(input logic [1:0] off, output logic [31:0] data);
        Addr = {28'h0, off};
        #1;
        data = Dout;
    endtask

    // One cycle: advance an edge, then compare COUNT and IRQ.
    task automatic step_cnt_irq();
        logic [31:0] d;
        tick();
        rd(2'd2, d);
        sb_pop(d);
        sb_pop(32'(IRQ));
    endtask

    task automatic step_irq();
        tick();
        sb_pop(32'(IRQ));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        reset = 1'b1;
        WE    = 1'b0;
        Addr  = '0;
        Din   = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset values at every offset.
        sb_push("rst_ctrl", 32'h0);
        sb_push("rst_preset", PRESET_RST);
        sb_push("rst_count", 32'h0);
        sb_push("rst_rsvd", 32'h0);
        sb_push("rst_irq", 32'h0);
        for (int i = 0; i < 4; i++) begin
            rd(2'(i), d);
            sb_pop(d);
        end
        sb_pop(32'(IRQ));

        // Reserved offset ignores writes, PRESET is R/W with 1-cycle latency.
        bus_wr(2'd3, 32'hFFFF_FFFF);
        sb_push("rsvd_rd", 32'h0);
        rd(2'd3, d);
        sb_pop(d);
        bus_wr(2'd1, 32'h1234_5678);
        sb_push("preset_rw", 32'h1234_5678);
        rd(2'd1, d);
        sb_pop(d);

        // Mode 0 one-shot, IM=1, PRESET=3.
        bus_wr(2'd1, 32'd3);
        bus_wr(2'd0, 32'h9);
        for (int k = 1; k <= 7; k++) begin
            sb_push($sformatf("m0_count_e%0d", k), (k >= 2 && k <= 5) ? 32'(5 - k) : 32'h0);
            sb_push($sformatf("m0_irq_e%0d", k), (k >= 6) ? 32'h1 : 32'h0);
            step_cnt_irq();
        end
        sb_push("m0_ctrl_after", 32'h8);
        rd(2'd0, d);
        sb_pop(d);
        bus_wr(2'd0, 32'h0);
        sb_push("m0_irq_cleared", 32'h0);
        sb_pop(32'(IRQ));

        // Mode 1 auto-reload: 1-cycle pulse every PRESET+3 = 6 cycles.
        bus_wr(2'd1, 32'd3);
        bus_wr(2'd0, 32'hB);
        for (int k = 1; k <= 20; k++) begin
            sb_push($sformatf("m1_irq_e%0d", k), (k >= 6 && (k % 6) == 0) ? 32'h1 : 32'h0);
            step_irq();
        end
        sb_push("m1_ctrl_en_kept", 32'hB);
        rd(2'd0, d);
        sb_pop(d);
        bus_wr(2'd0, 32'h0);

        // Mode 0 with IM=0: count completes silently, En clears.
        bus_wr(2'd1, 32'd2);
        bus_wr(2'd0, 32'h1);
        for (int k = 1; k <= 7; k++) begin
            sb_push($sformatf("nim_irq_e%0d", k), 32'h0);
            step_irq();
        end
        sb_push("nim_ctrl_done", 32'h0);
        rd(2'd0, d);
        sb_pop(d);
        bus_wr(2'd0, 32'h8);
        sb_push("nim_irq_after_im", 32'h0);
        sb_pop(32'(IRQ));
        tick();
        sb_push("nim_irq_after_im2", 32'h0);
        sb_pop(32'(IRQ));
        bus_wr(2'd0, 32'h0);

        // Disable mid-count, COUNT write ignored, re-enable reloads.
        bus_wr(2'd1, 32'd10);
        bus_wr(2'd0, 32'h1);
        for (int k = 1; k <= 7; k++) begin
            sb_push($sformatf("dis_count_e%0d", k), (k >= 2) ? 32'(12 - k) : 32'h0);
            sb_push($sformatf("dis_irq_e%0d", k), 32'h0);
            step_cnt_irq();
        end
        bus_wr(2'd0, 32'h0);
        sb_push("dis_count_frozen", 32'd5);
        rd(2'd2, d);
        sb_pop(d);
        sb_push("dis_count_hold", 32'd5);
        sb_push("dis_irq_hold", 32'h0);
        step_cnt_irq();
        bus_wr(2'd2, 32'h55);
        sb_push("count_wr_ignored", 32'd5);
        rd(2'd2, d);
        sb_pop(d);
        bus_wr(2'd0, 32'h1);
        tick();
        sb_push("reen_reload", 32'd10);
        sb_push("reen_irq", 32'h0);
        step_cnt_irq();
        bus_wr(2'd0, 32'h0);

        // PRESET=0 reaches INT after one CNT cycle: IRQ at edge 4.
        bus_wr(2'd1, 32'd0);
        bus_wr(2'd0, 32'h9);
        for (int k = 1; k <= 4; k++) begin
            sb_push($sformatf("p0_irq_e%0d", k), (k == 4) ? 32'h1 : 32'h0);
            step_irq();
        end
        bus_wr(2'd0, 32'h0);

        // CTRL write coinciding with INT keeps En=1 and restarts the count.
        bus_wr(2'd1, 32'd2);
        bus_wr(2'd0, 32'h9);
        repeat (4) tick();
        bus_wr(2'd0, 32'h9);
        sb_push("coin_ctrl", 32'h9);
        rd(2'd0, d);
        sb_pop(d);
        sb_push("coin_irq_set", 32'h1);
        sb_pop(32'(IRQ));
        tick();
        sb_push("coin_reload", 32'd2);
        sb_push("coin_irq_held", 32'h1);
        step_cnt_irq();

        // Reset wins over a simultaneous CTRL write.
        reset = 1'b1;
        Addr  = '0;
        Din   = 32'hF;
        WE    = 1'b1;
        tick();
        reset = 1'b0;
        WE    = 1'b0;
        sb_push("rst2_ctrl", 32'h0);
        sb_push("rst2_preset", PRESET_RST);
        sb_push("rst2_count", 32'h0);
        sb_push("rst2_irq", 32'h0);
        for (int i = 0; i < 3; i++) begin
            rd(2'(i), d);
            sb_pop(d);
        end
        sb_pop(32'(IRQ));

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
Memory-mapped timer/counter peripheral that answers the system bridge's accesses to timer address windows. The bridge instantiates it twice: TC0 at 0x7F00–0x7F0B and TC1 at 0x7F10–0x7F1B. It decodes the word offset, holds CTRL, PRESET and COUNT registers, and counts down through a 4-state FSM. It raises a maskable interrupt toward the CPU's interrupt-pending logic.

Parameters:
PRESET_RST, 32'h0, reset value of PRESET
COUNT_W, 32, width of PRESET/COUNT; read data is zero-extended to 32 bits

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
Addr  input  30  word address [31:2]; only Addr[3:2] is decoded (bridge already matched the window)
WE  input  1  write strobe; the bridge drives it only for full-word stores
Din  input  32  write data
Dout  output  32  read data, combinational on Addr[3:2]
IRQ  output  1  interrupt request, level, = irq_flag & CTRL.IM

Behaviour:
- Register map by Addr[3:2]:
  - 0 = CTRL: [3] IM, [2:1] Mode, [0] En; other bits read 0.
  - 1 = PRESET: R/W.
  - 2 = COUNT: read-only; writes are ignored.
  - 3 = reserved: reads 32'h0, writes ignored.
- Reset: CTRL=0, PRESET=PRESET_RST, COUNT=0, irq_flag=0, state=IDLE. IRQ=0 and Dout reflects the reset registers.
- Writes are committed on the edge where WE=1. Write-to-read latency is one cycle.
- FSM (one transition per edge):
  - IDLE: if En=1, go to LOAD.
  - LOAD: COUNT<=PRESET; go to CNT.
  - CNT: if En=0, go to IDLE with COUNT held. Else if COUNT>1, COUNT<=COUNT-1. Else COUNT<=0 and go to INT. PRESET=0 therefore reaches INT after a single CNT cycle.
  - INT: irq_flag<=1; go to IDLE.
    - Mode 0 (and modes 2/3): CTRL.En<=0, one-shot.
    - Mode 1: En is untouched, so IDLE->LOAD reloads automatically. Period = PRESET+3 cycles.
- irq_flag clearing:
  - Mode 0: held until any CTRL write or reset.
  - Mode 1: cleared automatically on the next edge, giving a 1-cycle pulse.
- Simultaneous events:
  - A CTRL write in the same cycle as INT takes priority for all CTRL bits, including En. irq_flag is still set that edge.
  - A CTRL write with En=0 during CNT sends the FSM to IDLE on the following edge. COUNT freezes at its current value.
  - A PRESET write during CNT does not affect the current count; it is used at the next LOAD.
  - A reset in any state wins over every write and FSM action.
- COUNT never wraps: it saturates at 0 and does not decrement below 0.

Optional Feature:
Macro TC_PRESCALE_EN.
- Defined: CTRL[7:4] is a R/W prescale field P, and a 4-bit prescale counter is added. In CNT, COUNT decrements only once every P+1 cycles. The prescale counter clears on LOAD and whenever En=0. With P=0, behaviour is identical to the undefined case.
- Undefined: CTRL[7:4] reads 0 and is not writable, and COUNT decrements every CNT cycle.

Test Plan:
- Reset, then read all four offsets -> CTRL=0, PRESET=PRESET_RST, COUNT=0, offset 3=0; IRQ=0.
- Write PRESET=3, then CTRL=0x9 (IM=1, Mode0, En=1) at edge 0 -> state LOAD@1, COUNT=3@2, 2@3, 1@4, 0@5; IRQ=1 from edge 6 and held; CTRL reads 0x8. A later CTRL write of 0x0 -> IRQ=0 on the next cycle.
- Mode 1: PRESET=3, CTRL=0xB -> IRQ pulses high exactly 1 cycle, every 6 cycles, for at least 3 periods; En stays 1.
- Mode 0 with IM=0 (CTRL=0x1), PRESET=2 -> count completes, En clears, IRQ stays 0. Then writing CTRL=0x8 -> IRQ remains 0, because the CTRL write clears irq_flag.
- Disable mid-count: PRESET=10, En=1; when COUNT=5, write CTRL=0 -> COUNT holds 5, no IRQ. A COUNT write of 0x55 is ignored. Re-enabling reloads COUNT to 10.
- Corner cases: PRESET=0, CTRL=0x9 -> IRQ at edge 4. A CTRL write of 0x9 coinciding with INT -> En stays 1 and a new count begins.
